// File: rtl/sr_window_scheduler.sv
// -----------------------------------------------------------------------------
// sr_window_scheduler
// Sequences the super-resolution datapath for one buffered frame. Pixels are
// visited in raster order. For each pixel the 3x3 neighbourhood is read from the
// frame buffer one tap per cycle, handed to the compute engine, and the engine's
// result is pushed into the output FIFO.
//
// Optional build macro:
//   SR_SCHED_REPLICATE_EN  out-of-frame taps clamp to the nearest in-frame pixel
//                          (border replication), and all 9 taps issue a read.
//                          When undefined, out-of-frame taps are zero and issue
//                          no read.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   frame_ready     1-cycle pulse: frame buffer fully written (IDLE only)
//   fb_rd, fb_addr  frame-buffer read strobe / address (registered)
//   fb_dout         read data, valid the cycle after fb_rd
//   win_data        9 taps, tap k = 3*dy+dx at [k*PIXEL_WIDTH +: PIXEL_WIDTH]
//   win_x, win_y    centre pixel coordinates
//   eng_start       1-cycle engine start pulse
//   eng_done        engine result strobe, eng_pixel the result
//   fifo_wr         output FIFO write (PUSH and not full)
//   fifo_wdata      registered engine result
//   fifo_full       output FIFO full; stalls PUSH
//   busy            high outside IDLE
//   frame_done      1-cycle pulse after the last pixel is written
// -----------------------------------------------------------------------------
module sr_window_scheduler #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PIXEL_WIDTH = 24,
  parameter int ADDR_WIDTH  = $clog2(WIDTH*HEIGHT),
  parameter int X_WIDTH     = $clog2(WIDTH),
  parameter int Y_WIDTH     = $clog2(HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_ready,
  output logic                     fb_rd,
  output logic [ADDR_WIDTH-1:0]    fb_addr,
  input  logic [PIXEL_WIDTH-1:0]   fb_dout,
  output logic [9*PIXEL_WIDTH-1:0] win_data,
  output logic [X_WIDTH-1:0]       win_x,
  output logic [Y_WIDTH-1:0]       win_y,
  output logic                     eng_start,
  input  logic                     eng_done,
  input  logic [PIXEL_WIDTH-1:0]   eng_pixel,
  output logic                     fifo_wr,
  output logic [PIXEL_WIDTH-1:0]   fifo_wdata,
  input  logic                     fifo_full,
  output logic                     busy,
  output logic                     frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_PUSH  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [3:0]               k_r;          // FETCH cycle index 0..9
  logic [X_WIDTH-1:0]       x_r;
  logic [Y_WIDTH-1:0]       y_r;
  logic [ADDR_WIDTH-1:0]    rb_r;         // y_r*WIDTH kept as a running sum
  logic [X_WIDTH-1:0]       x_adv_s;
  logic [Y_WIDTH-1:0]       y_adv_s;
  logic [ADDR_WIDTH-1:0]    rb_adv_s;
  logic                     last_pix_s;
  logic [ADDR_WIDTH:0]      req_s;        // {rd, addr} of the read to present next cycle
  logic                     fb_rd_r;
  logic [ADDR_WIDTH-1:0]    fb_addr_r;
  logic                     rd_d_r;       // was a read issued last cycle
  logic [3:0]               cap_idx_s;
  logic [PIXEL_WIDTH-1:0]   tap_r [0:8];
  logic [9*PIXEL_WIDTH-1:0] win_data_s;
  logic [PIXEL_WIDTH-1:0]   fifo_wdata_r;
  logic                     eng_start_r;
  logic                     busy_r;
  logic                     frame_done_r;

  // Read request for tap tk of the pixel at (tx,ty), row base trb.
  // Neighbour offsets are -WIDTH/0/+WIDTH and -1/0/+1, so no multiplier is needed.
  function automatic logic [ADDR_WIDTH:0] tap_req(
    input logic [X_WIDTH-1:0]    tx,
    input logic [Y_WIDTH-1:0]    ty,
    input logic [ADDR_WIDTH-1:0] trb,
    input logic [3:0]            tk
  );
    logic [1:0]            dx;
    logic [1:0]            dy;
    logic                  out_t;
    logic                  out_b;
    logic                  out_l;
    logic                  out_r;
    logic [ADDR_WIDTH-1:0] row_off;
    logic [ADDR_WIDTH-1:0] col_off;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd;
    case (tk)
      4'd0:    begin dy = 2'd0; dx = 2'd0; end
      4'd1:    begin dy = 2'd0; dx = 2'd1; end
      4'd2:    begin dy = 2'd0; dx = 2'd2; end
      4'd3:    begin dy = 2'd1; dx = 2'd0; end
      4'd4:    begin dy = 2'd1; dx = 2'd1; end
      4'd5:    begin dy = 2'd1; dx = 2'd2; end
      4'd6:    begin dy = 2'd2; dx = 2'd0; end
      4'd7:    begin dy = 2'd2; dx = 2'd1; end
      4'd8:    begin dy = 2'd2; dx = 2'd2; end
      default: begin dy = 2'd1; dx = 2'd1; end
    endcase
    out_t = (dy == 2'd0) && (ty == {Y_WIDTH{1'b0}});
    out_b = (dy == 2'd2) && (ty == Y_WIDTH'(HEIGHT-1));
    out_l = (dx == 2'd0) && (tx == {X_WIDTH{1'b0}});
    out_r = (dx == 2'd2) && (tx == X_WIDTH'(WIDTH-1));
    // An offset that would leave the frame collapses to 0, which is the
    // clamped (replicated) coordinate; in zero mode that read is suppressed.
    if (dy == 2'd0 && !out_t) begin
      row_off = ADDR_WIDTH'(0) - ADDR_WIDTH'(WIDTH);
    end else if (dy == 2'd2 && !out_b) begin
      row_off = ADDR_WIDTH'(WIDTH);
    end else begin
      row_off = {ADDR_WIDTH{1'b0}};
    end
    if (dx == 2'd0 && !out_l) begin
      col_off = {ADDR_WIDTH{1'b1}};
    end else if (dx == 2'd2 && !out_r) begin
      col_off = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      col_off = {ADDR_WIDTH{1'b0}};
    end
    addr = trb + ADDR_WIDTH'(tx) + row_off + col_off;
`ifdef SR_SCHED_REPLICATE_EN
    rd = 1'b1;
`else
    rd   = !(out_t || out_b || out_l || out_r);
    addr = rd ? addr : {ADDR_WIDTH{1'b0}};
`endif
    return {rd, addr};
  endfunction

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (frame_ready) state_nxt_s = ST_FETCH; else state_nxt_s = ST_IDLE;
      ST_FETCH: if (k_r == 4'd9) state_nxt_s = ST_START; else state_nxt_s = ST_FETCH;
      ST_START: state_nxt_s = ST_WAIT;
      ST_WAIT:  if (eng_done) state_nxt_s = ST_PUSH; else state_nxt_s = ST_WAIT;
      ST_PUSH: begin
        if (fifo_full) begin
          state_nxt_s = ST_PUSH;
        end else if (last_pix_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Raster advance of the pixel coordinates and the running row base.
  always_comb begin
    last_pix_s = (x_r == X_WIDTH'(WIDTH-1)) && (y_r == Y_WIDTH'(HEIGHT-1));
    if (x_r == X_WIDTH'(WIDTH-1)) begin
      x_adv_s  = {X_WIDTH{1'b0}};
      y_adv_s  = y_r + Y_WIDTH'(1'b1);
      rb_adv_s = rb_r + ADDR_WIDTH'(WIDTH);
    end else begin
      x_adv_s  = x_r + X_WIDTH'(1'b1);
      y_adv_s  = y_r;
      rb_adv_s = rb_r;
    end
  end

  // Next read request: tap 0 when entering FETCH, tap k+1 while fetching.
  always_comb begin
    req_s = {(ADDR_WIDTH+1){1'b0}};
    if (state_r == ST_IDLE && frame_ready) begin
      req_s = tap_req({X_WIDTH{1'b0}}, {Y_WIDTH{1'b0}}, {ADDR_WIDTH{1'b0}}, 4'd0);
    end else if (state_r == ST_PUSH && !fifo_full && !last_pix_s) begin
      req_s = tap_req(x_adv_s, y_adv_s, rb_adv_s, 4'd0);
    end else if (state_r == ST_FETCH && k_r < 4'd8) begin
      req_s = tap_req(x_r, y_r, rb_r, k_r + 4'd1);
    end else begin
      req_s = {(ADDR_WIDTH+1){1'b0}};
    end
  end

  assign cap_idx_s = k_r - 4'd1;

  // Datapath: read port, tap capture, coordinates, result and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_r          <= 4'd0;
      x_r          <= {X_WIDTH{1'b0}};
      y_r          <= {Y_WIDTH{1'b0}};
      rb_r         <= {ADDR_WIDTH{1'b0}};
      fb_rd_r      <= 1'b0;
      fb_addr_r    <= {ADDR_WIDTH{1'b0}};
      rd_d_r       <= 1'b0;
      fifo_wdata_r <= {PIXEL_WIDTH{1'b0}};
      eng_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        tap_r[i] <= {PIXEL_WIDTH{1'b0}};
      end
    end else begin
      fb_rd_r   <= req_s[ADDR_WIDTH];
      fb_addr_r <= req_s[ADDR_WIDTH-1:0];
      rd_d_r    <= fb_rd_r;

      if (state_r == ST_FETCH) begin
        k_r <= k_r + 4'd1;
      end else begin
        k_r <= 4'd0;
      end

      // Data for the tap requested last cycle is on fb_dout now; a tap
      // with no read behind it is zero padding.
      if (state_r == ST_FETCH && k_r != 4'd0) begin
        tap_r[cap_idx_s] <= rd_d_r ? fb_dout : {PIXEL_WIDTH{1'b0}};
      end

      if (state_r == ST_IDLE && frame_ready) begin
        x_r  <= {X_WIDTH{1'b0}};
        y_r  <= {Y_WIDTH{1'b0}};
        rb_r <= {ADDR_WIDTH{1'b0}};
      end else if (state_r == ST_PUSH && !fifo_full) begin
        if (last_pix_s) begin
          x_r  <= {X_WIDTH{1'b0}};
          y_r  <= {Y_WIDTH{1'b0}};
          rb_r <= {ADDR_WIDTH{1'b0}};
        end else begin
          x_r  <= x_adv_s;
          y_r  <= y_adv_s;
          rb_r <= rb_adv_s;
        end
      end

      if (state_r == ST_WAIT && eng_done) begin
        fifo_wdata_r <= eng_pixel;
      end

      eng_start_r  <= (state_nxt_s == ST_START);
      busy_r       <= (state_nxt_s != ST_IDLE);
      frame_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Pack the tap registers into the window bus.
  always_comb begin
    win_data_s = {(9*PIXEL_WIDTH){1'b0}};
    for (int i = 0; i < 9; i++) begin
      win_data_s[i*PIXEL_WIDTH +: PIXEL_WIDTH] = tap_r[i];
    end
  end

  assign fb_rd      = fb_rd_r;
  assign fb_addr    = fb_addr_r;
  assign win_data   = win_data_s;
  assign win_x      = x_r;
  assign win_y      = y_r;
  assign eng_start  = eng_start_r;
  assign fifo_wr    = (state_r == ST_PUSH) && !fifo_full;
  assign fifo_wdata = fifo_wdata_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule
